// File: rtl/seg_p2s_shifter_if.sv
//==============================================================================
// Module   : seg_p2s_shifter_if
// Brief    : Control and serial-output bundle of the segment parallel-to-serial
//            shifter.
// Revision : 1.0
//==============================================================================
`default_nettype none

interface seg_p2s_shifter_if #(
    parameter int DATA_BITS = 64
);
    logic                 start;
    logic                 auto;
    logic [DATA_BITS-1:0] P_Data;
    logic                 s_clk;
    logic                 sout;
    logic                 s_clrn;
    logic                 EN;
    logic                 busy;
    logic                 done;

    modport master (
        output start, auto, P_Data,
        input  s_clk, sout, s_clrn, EN, busy, done
    );

    modport slave (
        input  start, auto, P_Data,
        output s_clk, sout, s_clrn, EN, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/seg_p2s_shifter.sv
//==============================================================================
// Module   : seg_p2s_shifter
// Brief    : Shifts a captured segment image MSB-first into an external shift
//            register chain, generating serial clock, latch enable and clear.
// Revision : 1.0
//==============================================================================
`default_nettype none

module seg_p2s_shifter #(
    parameter int DATA_BITS = 64,
    parameter int HALF      = 2
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    seg_p2s_shifter_if.slave    bus
);

    localparam int c_BIT_W = $clog2(DATA_BITS);
    localparam int c_PH_W  = $clog2(HALF) + 1;
    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(DATA_BITS - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_ONE  = c_BIT_W'(1);
    localparam logic [c_PH_W-1:0]  c_PH_LAST  = c_PH_W'(HALF - 1);
    localparam logic [c_PH_W-1:0]  c_PH_ONE   = c_PH_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOW   = 2'd1,
        ST_HIGH  = 2'd2,
        ST_LATCH = 2'd3
    } state_t;

    state_t               r_state,  w_state_nxt;
    logic [DATA_BITS-1:0] r_shreg,  w_shreg_nxt;
    logic [c_BIT_W-1:0]   r_bit,    w_bit_nxt;
    logic [c_PH_W-1:0]    r_phase,  w_phase_nxt;
    logic                 r_s_clk,  w_s_clk_nxt;
    logic                 r_sout,   w_sout_nxt;
    logic                 r_en,     w_en_nxt;
    logic                 r_busy,   w_busy_nxt;
    logic                 r_done,   w_done_nxt;
    logic                 r_s_clrn;
    logic                 w_phase_end;

    assign w_phase_end = (r_phase == c_PH_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_shreg  <= '0;
            r_bit    <= '0;
            r_phase  <= '0;
            r_s_clk  <= 1'b1;
            r_sout   <= 1'b0;
            r_en     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_s_clrn <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_shreg  <= w_shreg_nxt;
            r_bit    <= w_bit_nxt;
            r_phase  <= w_phase_nxt;
            r_s_clk  <= w_s_clk_nxt;
            r_sout   <= w_sout_nxt;
            r_en     <= w_en_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_s_clrn <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        w_bit_nxt   = r_bit;
        w_phase_nxt = r_phase;
        w_s_clk_nxt = r_s_clk;
        w_sout_nxt  = r_sout;
        w_en_nxt    = r_en;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_s_clk_nxt = 1'b1;
                w_en_nxt    = 1'b0;
                w_busy_nxt  = 1'b0;
                if (bus.start || bus.auto) begin
                    w_shreg_nxt = bus.P_Data;
                    w_bit_nxt   = '0;
                    w_phase_nxt = '0;
                    w_sout_nxt  = bus.P_Data[DATA_BITS-1];
                    w_s_clk_nxt = 1'b0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = ST_LOW;
                end
            end
            ST_LOW: begin
                if (w_phase_end) begin
                    w_phase_nxt = '0;
                    w_s_clk_nxt = 1'b1;
                    w_state_nxt = ST_HIGH;
                end else begin
                    w_phase_nxt = r_phase + c_PH_ONE;
                end
            end
            ST_HIGH: begin
                if (w_phase_end) begin
                    w_phase_nxt = '0;
                    if (r_bit != c_BIT_LAST) begin
                        // sout changes on the falling edge so it is stable around the next rise
                        w_shreg_nxt = r_shreg << 1;
                        w_sout_nxt  = r_shreg[DATA_BITS-2];
                        w_s_clk_nxt = 1'b0;
                        w_bit_nxt   = r_bit + c_BIT_ONE;
                        w_state_nxt = ST_LOW;
                    end else begin
                        w_en_nxt    = 1'b1;
                        w_state_nxt = ST_LATCH;
                    end
                end else begin
                    w_phase_nxt = r_phase + c_PH_ONE;
                end
            end
            ST_LATCH: begin
                if (w_phase_end) begin
                    w_phase_nxt = '0;
                    w_en_nxt    = 1'b0;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_phase_nxt = r_phase + c_PH_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.s_clk  = r_s_clk;
    assign bus.sout   = r_sout;
    assign bus.s_clrn = r_s_clrn;
    assign bus.EN     = r_en;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;

endmodule

`default_nettype wire

// File: tb/tb_seg_p2s_shifter.sv
//==============================================================================
// Module   : tb_seg_p2s_shifter
// Brief    : Scoreboard bench for seg_p2s_shifter at HALF=1 and HALF=2.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_seg_p2s_shifter;

    localparam int N  = 64;
    localparam int H1 = 1;
    localparam int H2 = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    seg_p2s_shifter_if #(.DATA_BITS(N)) if1 ();
    seg_p2s_shifter_if #(.DATA_BITS(N)) if2 ();

    seg_p2s_shifter #(.DATA_BITS(N), .HALF(H1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    seg_p2s_shifter #(.DATA_BITS(N), .HALF(H2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    int tests = 0;
    int fails = 0;

    logic [N-1:0] exp_q0[$];
    logic [N-1:0] exp_q1[$];
    longint       rise_q[$];
    longint       gcyc = 0;

    logic [N-1:0] m_word [2];
    int           m_nbits[2];
    int           m_cyc  [2];
    int           m_en   [2];
    int           m_low  [2];
    int           m_high [2];
    bit           m_bad  [2];
    bit           m_act  [2];
    logic         m_psclk[2];
    logic         m_pbusy[2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] vec(input int id);
        if (id == 0) return {58'd0, if1.s_clk, if1.sout, if1.s_clrn, if1.EN, if1.busy, if1.done};
        else         return {58'd0, if2.s_clk, if2.sout, if2.s_clrn, if2.EN, if2.busy, if2.done};
    endfunction

    // Monitor: collects sout on each s_clk rise and scores the word when done pulses
    task automatic mon_step(input int id, input int h, input logic sclk, input logic so,
                            input logic busy, input logic en, input logic dn);
        logic [N-1:0] e;
        logic         rise, fall, have;
        if (!rst_n) begin
            m_act[id]   = 1'b0;
            m_psclk[id] = 1'b1;
            m_pbusy[id] = 1'b0;
            return;
        end
        if (busy && !m_pbusy[id]) begin
            m_act[id]   = 1'b1;
            m_word[id]  = '0;
            m_nbits[id] = 0;
            m_cyc[id]   = 0;
            m_en[id]    = 0;
            m_low[id]   = 0;
            m_high[id]  = 0;
            m_bad[id]   = 1'b0;
            if (id == 1) rise_q.push_back(gcyc);
        end else if (m_act[id]) begin
            m_cyc[id]++;
        end
        if (m_act[id]) begin
            rise = sclk && !m_psclk[id];
            fall = !sclk && m_psclk[id];
            if (rise) begin
                if (m_low[id] != h) m_bad[id] = 1'b1;
                m_low[id]   = 0;
                m_word[id]  = {m_word[id][N-2:0], so};
                m_nbits[id]++;
            end
            if (fall) begin
                if (m_nbits[id] > 0 && m_high[id] != h) m_bad[id] = 1'b1;
                m_high[id] = 0;
            end
            if (sclk) m_high[id]++;
            else      m_low[id]++;
            if (en) m_en[id]++;
        end
        if (dn) begin
            if (!m_act[id]) begin
                tests++;
                fails++;
                $display("FAIL done_unexpected[%0d]: got done=1, expected 0", id);
            end else begin
                have = 1'b1;
                e    = '0;
                if (id == 0 && exp_q0.size() > 0)      e = exp_q0.pop_front();
                else if (id == 1 && exp_q1.size() > 0) e = exp_q1.pop_front();
                else have = 1'b0;
                if (!have) begin
                    tests++;
                    fails++;
                    $display("FAIL done_no_expect[%0d]: got word %h, expected no transfer", id, m_word[id]);
                end else begin
                    chk($sformatf("word[%0d]", id), m_word[id], e);
                    chk($sformatf("nbits[%0d]", id), 64'(m_nbits[id]), 64'(N));
                    chk($sformatf("latency[%0d]", id), 64'(m_cyc[id]), 64'(2*h*N + h));
                    chk($sformatf("en_len[%0d]", id), 64'(m_en[id]), 64'(h));
                    chk($sformatf("phase_len[%0d]", id), 64'(m_bad[id]), 64'd0);
                end
                m_act[id] = 1'b0;
            end
        end
        m_psclk[id] = sclk;
        m_pbusy[id] = busy;
    endtask

    always @(negedge clk) begin
        gcyc++;
        mon_step(0, H1, if1.s_clk, if1.sout, if1.busy, if1.EN, if1.done);
        mon_step(1, H2, if2.s_clk, if2.sout, if2.busy, if2.EN, if2.done);
    end

    task automatic go(input int id, input logic [N-1:0] d, input bit push);
        @(posedge clk);
        #1;
        if (id == 0) begin
            if1.P_Data = d;
            if1.start  = 1'b1;
            if (push) exp_q0.push_back(d);
        end else begin
            if2.P_Data = d;
            if2.start  = 1'b1;
            if (push) exp_q1.push_back(d);
        end
        @(posedge clk);
        #1;
        if1.start = 1'b0;
        if2.start = 1'b0;
    endtask

    task automatic wait_done(input int id, input int limit, input string name);
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            #1;
            if ((id == 0) ? if1.done : if2.done) return;
        end
        tests++;
        fails++;
        $display("FAIL %s: no done within %0d cycles, expected done", name, limit);
    endtask

    task automatic wait_busy(input string name);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (if2.busy) return;
        end
        tests++;
        fails++;
        $display("FAIL %s: busy stayed 0, expected 1", name);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] d;
        bit           hit;
        if1.start = 1'b0; if1.auto = 1'b0; if1.P_Data = '0;
        if2.start = 1'b0; if2.auto = 1'b0; if2.P_Data = '0;

        // Reset values, then s_clrn rises on the first edge after release
        repeat (3) @(posedge clk);
        #1;
        chk("reset_vec1", vec(0), 64'h20);
        chk("reset_vec2", vec(1), 64'h20);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("clrn_before_edge", 64'(if2.s_clrn), 64'd0);
        @(posedge clk);
        #1;
        chk("clrn_after_edge1", 64'(if1.s_clrn), 64'd1);
        chk("clrn_after_edge2", 64'(if2.s_clrn), 64'd1);

        go(0, 64'h8000_0000_0000_0001, 1'b1);
        wait_done(0, 200, "t1_done");

        go(1, 64'hC0F9_A4B0_9992_82F8, 1'b1);
        wait_done(1, 400, "t2_done");

        // Extra start pulses and P_Data changes while busy must be ignored
        d = 64'h0123_4567_89AB_CDEF;
        go(0, d, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if1.start  = 1'b1;
            if1.P_Data = 64'hFFFF_0000_FFFF_0000 + 64'(i);
            @(posedge clk);
            #1;
            if1.start = 1'b0;
            repeat (8) @(posedge clk);
        end
        wait_done(0, 200, "t3_done");
        repeat (5) @(negedge clk);
        #1;
        chk("t3_no_extra_busy", 64'(if1.busy), 64'd0);

        // Continuous refresh: three back-to-back transfers
        rise_q.delete();
        @(posedge clk);
        #1;
        if2.P_Data = 64'h1111_2222_3333_4444;
        exp_q1.push_back(64'h1111_2222_3333_4444);
        if2.auto = 1'b1;
        wait_busy("t4_busy1");
        if2.P_Data = 64'hDEAD_BEEF_0000_FFFF;
        exp_q1.push_back(64'hDEAD_BEEF_0000_FFFF);
        wait_done(1, 400, "t4_done1");
        wait_busy("t4_busy2");
        if2.P_Data = 64'h5A5A_A5A5_F00F_0FF0;
        exp_q1.push_back(64'h5A5A_A5A5_F00F_0FF0);
        wait_done(1, 400, "t4_done2");
        wait_busy("t4_busy3");
        if2.auto = 1'b0;
        wait_done(1, 400, "t4_done3");
        repeat (4) @(negedge clk);
        #1;
        chk("t4_idle_after", 64'(if2.busy), 64'd0);
        chk("t4_nstarts", 64'(rise_q.size()), 64'd3);
        if (rise_q.size() >= 3) begin
            chk("t4_period1", 64'(rise_q[1] - rise_q[0]), 64'(2*H2*N + H2 + 1));
            chk("t4_period2", 64'(rise_q[2] - rise_q[1]), 64'(2*H2*N + H2 + 1));
        end

        // Reset mid-transfer at bit 20: immediate reset values, no done
        go(1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            #1;
            if (m_nbits[1] == 20) hit = 1'b1;
        end
        chk("t5_reached_bit20", 64'(hit), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_reset_vec", vec(1), 64'h20);
        repeat (3) @(posedge clk);
        #1;
        chk("t5_reset_hold", vec(1), 64'h20);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        chk("t5_idle_after_release", vec(1), 64'h28);
        go(1, 64'hA5A5_5A5A_0F0F_F0F0, 1'b1);
        wait_done(1, 400, "t5_done");

        repeat (5) @(negedge clk);
        chk("q0_empty", 64'(exp_q0.size()), 64'd0);
        chk("q1_empty", 64'(exp_q1.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seg_p2s_shifter.md
# seg_p2s_shifter

Parallel-to-serial shifter that sits directly downstream of the hex-to-segment encoder. It captures the 64-bit segment image (8 digits × {a,b,c,d,e,f,g,p}) and shifts it MSB-first into the board's external shift-register chain that drives the 8-digit display. It generates the serial clock, the serial data, a latch enable and a clear line, and reports busy/done to the control logic.

## Interface

Parameters:
- DATA_BITS, 64, number of bits shifted per transfer (≥ 2)
- HALF, 2, system clocks per serial-clock phase (≥ 1); one bit = 2·HALF clocks

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request a transfer; sampled only in IDLE
- auto  in  1  when 1, a new transfer starts from every IDLE cycle (continuous refresh)
- P_Data  in  DATA_BITS  parallel segment image; bit DATA_BITS-1 shifted first
- s_clk  out  1  serial clock to external register; data taken on its rising edge
- sout  out  1  serial data
- s_clrn  out  1  active-low clear for external register
- EN  out  1  output latch enable, high for HALF cycles after the last bit
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse when a transfer completes

## Operation

- All outputs registered. Reset values: s_clk=1, sout=0, s_clrn=0, EN=0, busy=0, done=0, state IDLE, shift register 0, counters 0.
- s_clrn: 0 while rst_n=0; 1 from the first clock edge after release, stays 1.
- States: IDLE, LOW, HIGH, LATCH.
- IDLE: s_clk=1, EN=0, busy=0. If start=1 or auto=1 at an edge: shreg←P_Data, bit counter←0, phase counter←0, sout←P_Data[DATA_BITS-1], s_clk←0, busy←1, go LOW.
- LOW: s_clk=0 for HALF cycles, then s_clk←1, go HIGH (rising edge mid-bit; sout stable across it).
- HIGH: s_clk=1 for HALF cycles. Then, if bit counter < DATA_BITS-1: shift shreg left by one, sout←next bit, s_clk←0, bit counter+1, go LOW. Else: EN←1, go LATCH.
- LATCH: s_clk=1, EN=1 for HALF cycles; then EN←0, busy←0, done←1, go IDLE.
- done is high exactly the first IDLE cycle after LATCH; 0 otherwise.
- P_Data is sampled only at the start edge; later changes do not affect the transfer in progress.
- start/auto while busy: ignored, not queued.
- Bit counter width clog2(DATA_BITS); phase counter width clog2(HALF)+1; no wrap beyond terminal values.

## Timing

- Start edge = edge at which IDLE samples start/auto=1 (call T0). s_clk falls and sout shows bit DATA_BITS-1 in the cycle after T0.
- Bit k (k=0 first, = P_Data[DATA_BITS-1-k]) drives sout from T0+2·HALF·k to T0+2·HALF·(k+1); s_clk rising edge at T0+2·HALF·k+HALF.
- EN high from T0+2·HALF·DATA_BITS for HALF cycles.
- done high in cycle following edge T0+2·HALF·DATA_BITS+HALF. Total start-to-done: 2·HALF·DATA_BITS+HALF cycles (DATA_BITS=64, HALF=2: 258).
- With auto=1, next transfer begins at the done cycle's edge: back-to-back period 2·HALF·DATA_BITS+HALF+1 cycles.
- start and auto both 1: single transfer (same as either alone).
- rst_n low mid-transfer: immediately all outputs to reset values (s_clrn=0 clears external chain), no done pulse; after release block is IDLE and requires new start.

## Test plan

- Reset: rst_n=0 → s_clk=1, sout=0, s_clrn=0, EN=0, busy=0, done=0; one edge after release s_clrn=1.
- Single transfer, HALF=1, P_Data=64'h8000_0000_0000_0001, one-cycle start → sout=1 for bit 0, 0 for bits 1–62, 1 for bit 63; 64 s_clk rising edges; EN high 1 cycle; done at cycle 129 after start edge; model collecting sout on s_clk rise reconstructs P_Data.
- HALF=2, P_Data=64'hC0F9_A4B0_9992_82F8 → reconstructed word equal; each s_clk phase 2 cycles; done at 258 cycles.
- start pulses and P_Data change during busy → no extra transfer, shifted word equals value captured at start.
- auto=1 held, P_Data changed between transfers → consecutive transfers separated by exactly one IDLE/done cycle, each carrying the P_Data sampled at its own start edge.
- rst_n asserted at bit 20 → outputs to reset values same cycle, no done, no EN; after release, start produces a full correct transfer.
